irq_priority_controller: RTL and testbench

Upstream companion of the CPU control unit. It collects up to `IRQ_COUNT` external interrupt lines and latches them as pending flags. It arbitrates them by fixed priority, with line 0 highest, and presents one locked request (`irq` + `vector`) that stays stable until the control unit returns a one-cycle `ack`. Mask, flag and mode registers are exposed as I/O-space registers on the shared CPU bus.

---
 rtl/irq_priority_controller_pkg.sv | 14 +
 rtl/irq_priority_controller_sync_edge.sv | 29 ++
 rtl/irq_priority_controller.sv | 157 +++++++++++++++
 tb/tb_irq_priority_controller.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_priority_controller_pkg.sv
// Shared constants for the interrupt priority controller: I/O register map and FSM encoding.
package irq_priority_controller_pkg;

    localparam logic [15:0] IRQC_MODE_ADDR = 16'h0039;
    localparam logic [15:0] IRQC_FLAG_ADDR = 16'h003A;
    localparam logic [15:0] IRQC_MASK_ADDR = 16'h003B;

    typedef enum logic [1:0] {
        IRQC_IDLE = 2'd0,
        IRQC_LOCK = 2'd1,
        IRQC_HOLD = 2'd2
    } irqc_state_t;

endpackage

// File: rtl/irq_priority_controller_sync_edge.sv
// Per-line two-flop synchronizer followed by a rising-edge detector on the synchronized level.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/irq_priority_controller.sv
// Fixed-priority interrupt controller: pending flags, mask/mode registers on the I/O bus,
// and a locked request (irq + vector) held stable until the control unit acknowledges it.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no request; lock the lowest eligible line when one appears
//   LOCK  | irq=1, vector=locked index+1, frozen until ack
//   HOLD  | one cycle with irq=0 so the next fetch sees the request drop
module irq_priority_controller
    import irq_priority_controller_pkg::*;
#(
    parameter int              IRQ_COUNT    = 4,
    parameter int              DATA_WIDTH   = 8,
    parameter int              ADDR_WIDTH   = 16,
    parameter int              I_ADDR_WIDTH = 10,
    parameter logic [15:0]     MODE_ADDR    = IRQC_MODE_ADDR,
    parameter logic [15:0]     FLAG_ADDR    = IRQC_FLAG_ADDR,
    parameter logic [15:0]     MASK_ADDR    = IRQC_MASK_ADDR
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IRQ_COUNT-1:0]    irq_lines,
    input  logic                    global_ie,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    input  logic                    ack,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    inout  wire  [DATA_WIDTH-1:0]   bus_data,
    input  logic                    io_cs,
    input  logic                    io_we,
    input  logic                    io_oe
);

    localparam int IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

    logic [IRQ_COUNT-1:0] sync_level;
    logic [IRQ_COUNT-1:0] sync_rise;

    for (genvar g = 0; g < IRQ_COUNT; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .reset   (reset),
            .line_in (irq_lines[g]),
            .level   (sync_level[g]),
            .rise    (sync_rise[g])
        );
    end

    logic [IRQ_COUNT-1:0] mode_q;
    logic [IRQ_COUNT-1:0] mask_q;
    logic [IRQ_COUNT-1:0] flag_q;
    logic [IRQ_COUNT-1:0] flag_d;
    logic [IRQ_COUNT-1:0] set_vec;
    logic [IRQ_COUNT-1:0] sw_clr;
    logic [IRQ_COUNT-1:0] ack_clr;
    logic [IRQ_COUNT-1:0] eligible;
    logic [IRQ_COUNT-1:0] wr_data;

    irqc_state_t          state_q;
    irqc_state_t          state_d;
    logic [IDX_W-1:0]     lock_idx_q;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_valid;

    logic                 bus_wr;
    logic                 sel_mode;
    logic                 sel_flag;
    logic                 sel_mask;
    logic                 rd_hit;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                 unused_bus_bits;

    assign bus_wr   = io_cs && io_we;
    assign sel_mode = (bus_addr == ADDR_WIDTH'(MODE_ADDR));
    assign sel_flag = (bus_addr == ADDR_WIDTH'(FLAG_ADDR));
    assign sel_mask = (bus_addr == ADDR_WIDTH'(MASK_ADDR));
    assign wr_data  = bus_data[IRQ_COUNT-1:0];
    assign unused_bus_bits = &{1'b0, bus_data};

    // Set has priority over either clear source in the same cycle.
    assign set_vec  = (mode_q & sync_rise) | (~mode_q & sync_level);
    assign sw_clr   = (bus_wr && sel_flag) ? wr_data : '0;
    assign flag_d   = (flag_q & ~(sw_clr | ack_clr)) | set_vec;
    assign eligible = global_ie ? (flag_q & mask_q) : '0;

    always_comb begin
        ack_clr = '0;
        if (state_q == IRQC_LOCK && ack) begin
            ack_clr[lock_idx_q] = 1'b1;
        end
    end

    // Descending scan so the lowest eligible index is the last assignment.
    always_comb begin
        win_valid = |eligible;
        win_idx   = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IRQC_IDLE: if (win_valid) state_d = IRQC_LOCK;
            IRQC_LOCK: if (ack)       state_d = IRQC_HOLD;
            IRQC_HOLD:                state_d = IRQC_IDLE;
            default:                  state_d = IRQC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IRQC_IDLE;
            lock_idx_q <= '0;
            flag_q     <= '0;
            mode_q     <= '0;
            mask_q     <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            if (state_q == IRQC_IDLE && win_valid) begin
                lock_idx_q <= win_idx;
            end
            if (bus_wr && sel_mode) begin
                mode_q <= wr_data;
            end
            if (bus_wr && sel_mask) begin
                mask_q <= wr_data;
            end
        end
    end

    assign irq    = (state_q == IRQC_LOCK);
    assign vector = irq ? (I_ADDR_WIDTH'(lock_idx_q) + I_ADDR_WIDTH'(1)) : '0;

    // Read path is combinational so the control unit can sample it in the same cycle.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        if (sel_mode) begin
            rd_hit  = 1'b1;
            rd_data = DATA_WIDTH'(mode_q);
        end else if (sel_flag) begin
            rd_hit  = 1'b1;
            rd_data = DATA_WIDTH'(flag_q);
        end else if (sel_mask) begin
            rd_hit  = 1'b1;
            rd_data = DATA_WIDTH'(mask_q);
        end
    end

    assign bus_data = (io_cs && io_oe && rd_hit) ? rd_data : 'z;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Bench for irq_priority_controller: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model built from sample history and the pending/lock rules.
module tb_irq_priority_controller;
    import irq_priority_controller_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_lines;
    logic          global_ie;
    logic          irq;
    logic [IW-1:0] vector;
    logic          ack;
    logic [AW-1:0] bus_addr;
    wire  [DW-1:0] bus_data;
    logic          io_cs, io_we, io_oe;
    logic          tb_drv;
    logic [DW-1:0] tb_wdata;

    assign bus_data = tb_drv ? tb_wdata : 'z;

    irq_priority_controller dut (
        .clk       (clk),
        .reset     (reset),
        .irq_lines (irq_lines),
        .global_ie (global_ie),
        .irq       (irq),
        .vector    (vector),
        .ack       (ack),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .io_cs     (io_cs),
        .io_we     (io_we),
        .io_oe     (io_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[k] = irq_lines as sampled k+1 edges ago; the synchronized level is two samples old.
    logic [N-1:0] hist [3];
    logic [N-1:0] m_mode, m_mask, m_flag;
    logic [N-1:0] m_set, m_clr, m_elig;
    int           m_phase;   // 0 idle, 1 locked, 2 hold
    int           m_idx;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == IRQC_MODE_ADDR) return DW'(m_mode);
        if (a == IRQC_FLAG_ADDR) return DW'(m_flag);
        if (a == IRQC_MASK_ADDR) return DW'(m_mask);
        return '0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) hist[k] = '0;
            m_mode = '0; m_mask = '0; m_flag = '0; m_phase = 0; m_idx = 0;
        end else begin
            m_set  = (m_mode & hist[1] & ~hist[2]) | (~m_mode & hist[1]);
            m_clr  = (io_cs && io_we && bus_addr == IRQC_FLAG_ADDR) ? tb_wdata[N-1:0] : '0;
            m_elig = global_ie ? (m_flag & m_mask) : '0;
            if (m_phase == 0) begin
                if (m_elig != 0) begin
                    m_idx   = lowest(m_elig);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    m_clr[m_idx] = 1'b1;
                    m_phase      = 2;
                end
            end else begin
                m_phase = 0;
            end
            m_flag = (m_flag & ~m_clr) | m_set;
            if (io_cs && io_we && bus_addr == IRQC_MODE_ADDR) m_mode = tb_wdata[N-1:0];
            if (io_cs && io_we && bus_addr == IRQC_MASK_ADDR) m_mask = tb_wdata[N-1:0];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = irq_lines;
        end
    end

    always @(negedge clk) begin
        check("model_irq", irq, (m_phase == 1) ? 1 : 0);
        check("model_vector", vector, (m_phase == 1) ? m_idx + 1 : 0);
    end

    // ---------------- stimulus helpers (enter and leave just after a negedge) ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        io_cs = 1'b1; io_we = 1'b1; bus_addr = a; tb_wdata = d; tb_drv = 1'b1;
        @(negedge clk);
        io_cs = 1'b0; io_we = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic bus_read_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        io_cs = 1'b1; io_oe = 1'b1; bus_addr = a;
        #1;
        check(name, bus_data, exp);
        io_cs = 1'b0; io_oe = 1'b0;
    endtask

    task automatic check_undriven(input string name, input logic [AW-1:0] a, input logic oe);
        io_cs = 1'b1; io_oe = oe; bus_addr = a;
        #1;
        n_checks++;
        if (!(bus_data === 8'hzz || bus_data === 8'h00)) begin
            n_fail++;
            $display("FAIL %s: bus_data 0x%0h, expected undriven (Z)", name, bus_data);
        end
        io_cs = 1'b0; io_oe = 1'b0;
    endtask

    task automatic pulse_lines(input logic [N-1:0] v);
        irq_lines = v;
        @(negedge clk);
        irq_lines = '0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget, output int cycles);
        cycles = 0;
        while (irq !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check(name, irq, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int low;
        int r;
        logic [AW-1:0] addrs [3];
        addrs[0] = IRQC_MODE_ADDR; addrs[1] = IRQC_FLAG_ADDR; addrs[2] = IRQC_MASK_ADDR;

        reset = 1'b1; irq_lines = '0; global_ie = 1'b0; ack = 1'b0;
        bus_addr = '0; io_cs = 1'b0; io_we = 1'b0; io_oe = 1'b0; tb_drv = 1'b0; tb_wdata = '0;
        tick(3);
        check("reset_irq", irq, 0);
        check("reset_vector", vector, 0);
        reset = 1'b0;
        bus_read_check("reset_flag", IRQC_FLAG_ADDR, 8'h00);
        bus_read_check("reset_mask", IRQC_MASK_ADDR, 8'h00);
        bus_read_check("reset_mode", IRQC_MODE_ADDR, 8'h00);

        // edge mode, single line
        bus_write(IRQC_MODE_ADDR, 8'h0F);
        bus_write(IRQC_MASK_ADDR, 8'h04);
        global_ie = 1'b1;
        pulse_lines(4'b0100);
        wait_irq("edge_irq", 8, cyc);
        check("edge_latency", cyc, 3);
        check("edge_vector", vector, 3);
        bus_read_check("edge_flag_set", IRQC_FLAG_ADDR, 8'h04);
        pulse_ack();
        check("edge_irq_after_ack", irq, 0);
        bus_read_check("edge_flag_cleared", IRQC_FLAG_ADDR, 8'h00);
        tick(5);
        check("edge_irq_stays_low", irq, 0);

        // priority between lines 1 and 3
        bus_write(IRQC_MASK_ADDR, 8'h0F);
        pulse_lines(4'b1010);
        wait_irq("prio_first_irq", 8, cyc);
        check("prio_first_vector", vector, 2);
        pulse_ack();
        wait_irq("prio_second_irq", 6, cyc);
        check("prio_second_vector", vector, 4);
        pulse_ack();
        tick(3);

        // lock stability against new arrival and global_ie drop
        pulse_lines(4'b1000);
        wait_irq("lock_irq", 8, cyc);
        check("lock_vector", vector, 4);
        pulse_lines(4'b0001);
        tick(4);
        global_ie = 1'b0;
        tick(3);
        check("lock_irq_held", irq, 1);
        check("lock_vector_held", vector, 4);
        bus_read_check("lock_flags", IRQC_FLAG_ADDR, 8'h09);
        pulse_ack();
        tick(4);
        check("lock_gie_low_no_irq", irq, 0);
        global_ie = 1'b1;
        wait_irq("lock_line0_irq", 6, cyc);
        check("lock_line0_vector", vector, 1);
        pulse_ack();
        tick(3);

        // level mode, line held through ack
        bus_write(IRQC_MODE_ADDR, 8'h00);
        irq_lines = 4'b0010;
        wait_irq("level_irq", 8, cyc);
        check("level_vector", vector, 2);
        pulse_ack();
        bus_read_check("level_flag_reset", IRQC_FLAG_ADDR, 8'h02);
        low = 0;
        while (irq !== 1'b1 && low < 6) begin
            low++;
            tick(1);
        end
        check("level_low_cycles", low, 2);
        check("level_reassert_vector", vector, 2);
        global_ie = 1'b0;
        irq_lines = '0;
        pulse_ack();
        tick(4);
        bus_write(IRQC_FLAG_ADDR, 8'h0F);
        bus_read_check("level_flags_cleared", IRQC_FLAG_ADDR, 8'h00);

        // bus access
        bus_write(IRQC_MODE_ADDR, 8'h0F);
        bus_write(IRQC_MASK_ADDR, 8'h00);
        global_ie = 1'b1;
        pulse_lines(4'b0010);
        tick(3);
        bus_read_check("bus_flag_pending", IRQC_FLAG_ADDR, 8'h02);
        bus_write(IRQC_FLAG_ADDR, 8'h02);
        bus_read_check("bus_flag_w1c", IRQC_FLAG_ADDR, 8'h00);
        bus_write(IRQC_MASK_ADDR, 8'hFF);
        bus_read_check("bus_mask_trunc", IRQC_MASK_ADDR, 8'h0F);
        bus_read_check("bus_mode_read", IRQC_MODE_ADDR, 8'h0F);
        check_undriven("bus_nomatch_z", 16'h003C, 1'b1);
        check_undriven("bus_no_oe_z", IRQC_MASK_ADDR, 1'b0);

        // reset while locked
        pulse_lines(4'b0001);
        wait_irq("rst_irq", 8, cyc);
        check("rst_vector", vector, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_irq_drop", irq, 0);
        check("rst_vector_zero", vector, 0);
        bus_read_check("rst_flag_zero", IRQC_FLAG_ADDR, 8'h00);
        bus_read_check("rst_mask_zero", IRQC_MASK_ADDR, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        pulse_ack();
        tick(3);
        check("rst_ack_ignored", irq, 0);
        bus_read_check("rst_flag_after_ack", IRQC_FLAG_ADDR, 8'h00);

        // randomized traffic
        bus_write(IRQC_MODE_ADDR, DW'($urandom));
        bus_write(IRQC_MASK_ADDR, DW'($urandom));
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 3) == 0) irq_lines = N'($urandom);
            ack       = ($urandom_range(0, 3) == 0);
            global_ie = ($urandom_range(0, 9) != 0);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                io_cs = 1'b1; io_we = 1'b1; tb_drv = 1'b1;
                bus_addr = addrs[$urandom_range(0, 2)];
                tb_wdata = DW'($urandom);
            end else if (r == 1) begin
                bus_addr = addrs[$urandom_range(0, 2)];
                bus_read_check("rand_read", bus_addr, model_read(bus_addr));
            end
            @(negedge clk);
            io_cs = 1'b0; io_we = 1'b0; tb_drv = 1'b0;
        end
        ack = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
